// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog controller slice.
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    KICK    = 2'd2,
    TIMEOUT = 2'd3
  } wdt_ctrl_state_e;

  localparam logic [1:0] WDT_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] WDT_ADDR_TOCNT  = 2'd1;
  localparam logic [1:0] WDT_ADDR_KICK   = 2'd2;
  localparam logic [1:0] WDT_ADDR_STATUS = 2'd3;

  localparam logic [31:0] WDT_KICK_KEY = 32'h5A5A_A5A5;

  localparam int unsigned WDT_DEF_STRETCH = 4;
  localparam int unsigned WDT_DEF_GRACE   = 1024;
  localparam logic [31:0] WDT_DEF_TOCNT   = 32'h0000_FFFF;

endpackage

// File: rtl/wdt_sync2.sv
// Generic two-flop synchroniser with asynchronous active-low reset.
module wdt_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/wdt_ctrl.sv
// Register-mapped watchdog sequencer: enable level, stretched kick, locked timeout count,
// timeout escalation. Define WDT_CTRL_PRE_IRQ_EN for the irq + grace-period build.
module wdt_ctrl
  import wdt_pkg::*;
#(
  parameter int unsigned  STRETCH   = WDT_DEF_STRETCH,
`ifdef WDT_CTRL_PRE_IRQ_EN
  parameter int unsigned  GRACE     = WDT_DEF_GRACE,
`endif
  parameter logic [31:0]  DEF_TOCNT = WDT_DEF_TOCNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        WDEN,
  output logic        WDLIVE,
  output logic [31:0] WTOCNT,
  input  logic        WTO,
  output logic        irq,
  output logic        sys_rst_req
);

  localparam int KW = $clog2(STRETCH + 1);
  localparam logic [KW-1:0] KICK_LAST = KW'(STRETCH - 1);

  wdt_ctrl_state_e state, state_nxt;
  logic [KW-1:0]   kick_cnt;
  logic            key_err;
  logic            wto_s;
  logic [31:0]     rd_val;

  logic wr, rd, ctrl_wr, en_wr, dis_wr, tocnt_wr, kick_wr, kick_ok, kick_bad, timeout_evt;

  wdt_sync2 #(.W(1)) u_wto_sync (
    .clk (clk),
    .rst (rst),
    .d   (WTO),
    .q   (wto_s)
  );

  assign wr          = req & we;
  assign rd          = req & ~we;
  assign ctrl_wr     = wr && (addr == WDT_ADDR_CTRL);
  assign en_wr       = ctrl_wr & wdata[0];
  assign dis_wr      = ctrl_wr & ~wdata[0];
  assign tocnt_wr    = wr && (addr == WDT_ADDR_TOCNT) && (state == IDLE);
  assign kick_wr     = wr && (addr == WDT_ADDR_KICK);
  assign kick_ok     = kick_wr && (state == RUN) && (wdata == WDT_KICK_KEY);
  // Kicks during an active stretch are silently dropped, not flagged.
  assign kick_bad    = kick_wr && (state != KICK) && !kick_ok;
  assign timeout_evt = wto_s && ((state == RUN) || (state == KICK));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Disable beats timeout, timeout beats kick.
  always_comb begin
    state_nxt = state;
    WDEN      = 1'b0;
    WDLIVE    = 1'b0;
    case (state)
      IDLE: begin
        if (en_wr) state_nxt = RUN;
      end
      RUN: begin
        WDEN = 1'b1;
        if (dis_wr)           state_nxt = IDLE;
        else if (timeout_evt) state_nxt = TIMEOUT;
        else if (kick_ok)     state_nxt = KICK;
      end
      KICK: begin
        WDEN   = 1'b1;
        WDLIVE = 1'b1;
        if (dis_wr)                      state_nxt = IDLE;
        else if (timeout_evt)            state_nxt = TIMEOUT;
        else if (kick_cnt == KICK_LAST)  state_nxt = RUN;
      end
      TIMEOUT: begin
        WDEN = 1'b1;
        if (dis_wr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // KICK is only entered from RUN, where the counter is held at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kick_cnt <= '0;
    end else if (state == KICK) begin
      kick_cnt <= kick_cnt + KW'(1);
    end else begin
      kick_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WTOCNT  <= DEF_TOCNT;
      key_err <= 1'b0;
    end else begin
      if (tocnt_wr) WTOCNT <= wdata;
      if (kick_bad)
        key_err <= 1'b1;
      else if (rd && (addr == WDT_ADDR_STATUS))
        key_err <= 1'b0;
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      WDT_ADDR_CTRL:   rd_val[0]   = (state != IDLE);
      WDT_ADDR_TOCNT:  rd_val      = WTOCNT;
      WDT_ADDR_STATUS: rd_val[3:0] = {key_err, (state == KICK), (state == TIMEOUT), (state != IDLE)};
      default:         rd_val      = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= req;
      rdata <= rd ? rd_val : '0;
    end
  end

`ifdef WDT_CTRL_PRE_IRQ_EN
  logic [31:0] grace_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grace_cnt <= '0;
    end else if (state != TIMEOUT) begin
      grace_cnt <= '0;
    end else if (grace_cnt != '1) begin
      grace_cnt <= grace_cnt + 32'd1;
    end
  end

  assign irq         = (state == TIMEOUT);
  assign sys_rst_req = (state == TIMEOUT) && (grace_cnt >= 32'(GRACE));
`else
  assign irq         = 1'b0;
  assign sys_rst_req = (state == TIMEOUT);
`endif

endmodule

// File: tb/tb_wdt_ctrl.sv
// Randomized self-checking bench for wdt_ctrl against a behavioural watchdog model.
module tb_wdt_ctrl;

  localparam int STRETCH = 4;
`ifdef WDT_CTRL_PRE_IRQ_EN
  localparam int GRACE = 8;
`endif
  localparam logic [31:0] KEY = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic        WTO = 1'b0;
  logic [31:0] rdata;
  logic        ack;
  logic        WDEN;
  logic        WDLIVE;
  logic [31:0] WTOCNT;
  logic        irq;
  logic        sys_rst_req;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  wdt_ctrl #(
    .STRETCH   (STRETCH),
`ifdef WDT_CTRL_PRE_IRQ_EN
    .GRACE     (GRACE),
`endif
    .DEF_TOCNT (32'h0000_FFFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .ack         (ack),
    .WDEN        (WDEN),
    .WDLIVE      (WDLIVE),
    .WTOCNT      (WTOCNT),
    .WTO         (WTO),
    .irq         (irq),
    .sys_rst_req (sys_rst_req)
  );

  always #5 clk = ~clk;

  // Behavioural view: enabled / timed-out flags, remaining kick cycles, cycles since timeout.
  bit          m_en, m_to, m_kerr, m_s1, m_s2;
  int          m_kick, m_grace;
  logic [31:0] m_tocnt;
  bit          e_ack;
  logic [31:0] e_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_irq();
`ifdef WDT_CTRL_PRE_IRQ_EN
    return m_to;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_sys();
`ifdef WDT_CTRL_PRE_IRQ_EN
    return m_to && (m_grace >= GRACE);
`else
    return m_to;
`endif
  endfunction

  function automatic bit tmo_sig();
`ifdef WDT_CTRL_PRE_IRQ_EN
    return irq;
`else
    return sys_rst_req;
`endif
  endfunction

  task automatic model_reset();
    m_en = 0; m_to = 0; m_kerr = 0; m_s1 = 0; m_s2 = 0;
    m_kick = 0; m_grace = 0; m_tocnt = 32'h0000_FFFF;
    e_ack = 0; e_rdata = 0;
  endtask

  task automatic model_step();
    logic [31:0] rv;
    bit wr, rd, dis, en, kickw, evt;
    wr = req && we;
    rd = req && !we;
    case (addr)
      2'd0:    rv = {31'd0, m_en};
      2'd1:    rv = m_tocnt;
      2'd3:    rv = {28'd0, m_kerr, (m_kick > 0) ? 1'b1 : 1'b0, m_to, m_en};
      default: rv = 32'd0;
    endcase
    e_ack   = req;
    e_rdata = rd ? rv : 32'd0;
    dis   = wr && addr == 2'd0 && !wdata[0];
    en    = wr && addr == 2'd0 && wdata[0];
    kickw = wr && addr == 2'd2;
    evt   = m_s2 && m_en && !m_to;
    if (kickw && m_kick == 0 && !(m_en && !m_to && wdata == KEY)) m_kerr = 1;
    else if (rd && addr == 2'd3) m_kerr = 0;
    if (!m_en) begin
      if (en) m_en = 1;
      if (wr && addr == 2'd1) m_tocnt = wdata;
    end else if (dis) begin
      m_en = 0; m_to = 0; m_kick = 0; m_grace = 0;
    end else if (m_to) begin
      if (m_grace < 1000000) m_grace++;
    end else if (evt) begin
      m_to = 1; m_kick = 0; m_grace = 0;
    end else if (m_kick > 0) begin
      m_kick--;
    end else if (kickw && wdata == KEY) begin
      m_kick = STRETCH;
    end
    m_s2 = m_s1;
    m_s1 = WTO;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ack", {31'd0, ack}, {31'd0, e_ack});
      chk("rdata", rdata, e_rdata);
      chk("WDEN", {31'd0, WDEN}, {31'd0, m_en});
      chk("WDLIVE", {31'd0, WDLIVE}, (m_kick > 0) ? 32'd1 : 32'd0);
      chk("WTOCNT", WTOCNT, m_tocnt);
      chk("irq", {31'd0, irq}, {31'd0, exp_irq()});
      chk("sys_rst_req", {31'd0, sys_rst_req}, {31'd0, exp_sys()});
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
  endtask

  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    req = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
  endtask

  task automatic reset_lits(input string tag);
    chk({tag, "_WDEN"}, {31'd0, WDEN}, 32'd0);
    chk({tag, "_WDLIVE"}, {31'd0, WDLIVE}, 32'd0);
    chk({tag, "_irq"}, {31'd0, irq}, 32'd0);
    chk({tag, "_sys_rst_req"}, {31'd0, sys_rst_req}, 32'd0);
    chk({tag, "_ack"}, {31'd0, ack}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_WTOCNT"}, WTOCNT, 32'h0000_FFFF);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    reset_lits(tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    int n;
    model_reset();
    #21;
    reset_lits("por");
    #1;
    rst = 1'b1;
    chk_on = 1'b1;

    bus(1'b0, 2'd3, 32'd0);
    chk("status_after_reset", rdata, 32'd0);
    chk("ack_one_cycle", {31'd0, ack}, 32'd1);

    bus(1'b1, 2'd1, 32'd100);
    bus(1'b1, 2'd0, 32'd1);
    chk("wden_rise", {31'd0, WDEN}, 32'd1);
    bus(1'b1, 2'd1, 32'd7);
    chk("tocnt_locked", WTOCNT, 32'd100);

    bus(1'b1, 2'd2, KEY);
    chk("kick_rise", {31'd0, WDLIVE}, 32'd1);
    n = 1;
    bus(1'b1, 2'd2, KEY);
    if (WDLIVE) n++;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (WDLIVE) n++;
    end
    chk("kick_width", n, 32'd4);
    bus(1'b0, 2'd3, 32'd0);
    chk("status_no_keyerr", rdata, 32'd1);

    bus(1'b1, 2'd2, 32'h1234_5678);
    chk("bad_key_no_live", {31'd0, WDLIVE}, 32'd0);
    bus(1'b0, 2'd3, 32'd0);
    chk("status_keyerr", rdata, 32'd9);
    bus(1'b0, 2'd3, 32'd0);
    chk("status_keyerr_clr", rdata, 32'd1);

    WTO = 1'b1;
    tick();
    WTO = 1'b0;
    n = 1;
    while (!tmo_sig() && n < 20) begin
      tick();
      n++;
    end
    chk("wto_latency", n, 32'd3);
`ifdef WDT_CTRL_PRE_IRQ_EN
    n = 0;
    while (!sys_rst_req && n < 40) begin
      tick();
      n++;
    end
    chk("grace_cycles", n, 32'd8);
    bus(1'b1, 2'd0, 32'd0);
    chk("dis_irq", {31'd0, irq}, 32'd0);
    chk("dis_sys", {31'd0, sys_rst_req}, 32'd0);
    chk("dis_wden", {31'd0, WDEN}, 32'd0);
    bus(1'b1, 2'd0, 32'd1);
    WTO = 1'b1;
    tick();
    WTO = 1'b0;
    repeat (4) tick();
`else
    chk("nomacro_irq", {31'd0, irq}, 32'd0);
    chk("nomacro_sys", {31'd0, sys_rst_req}, 32'd1);
`endif
    chk("timeout_wden", {31'd0, WDEN}, 32'd1);
    do_reset("mid_timeout");

    for (int c = 0; c < 3000; c++) begin
      req   = ($urandom_range(0, 9) < 6);
      we    = $urandom_range(0, 1) == 1;
      addr  = 2'($urandom_range(0, 3));
      wdata = $urandom;
      if (addr == 2'd2 && $urandom_range(0, 3) != 0) wdata = KEY;
      if (addr == 2'd0) wdata[0] = ($urandom_range(0, 3) != 0);
      WTO   = ($urandom_range(0, 29) == 0);
      tick();
      if ($urandom_range(0, 599) == 0) do_reset("rand_reset");
    end

    req = 1'b0; we = 1'b0; WTO = 1'b0;
    tick();
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
